// File: rtl/vlsu_shuffle_pkg.sv
// Shared types, constants and sequential-to-lane index functions for the
// multi-queue load shuffle unit.
package vlsu_shuffle_pkg;

    localparam int NrExits       = 4;
    localparam int DLEN          = 64;
    localparam int NbPerLane     = DLEN / 4;
    localparam int InfoDepth     = 4;
    localparam int LaneDepth     = 2;
    localparam int NrReqIds      = 8;
    localparam int NrVRFSets     = 64;

    localparam int SetBits       = $clog2(NrVRFSets);
    localparam int ReqIdBits     = $clog2(NrReqIds);
    localparam int LogNrExits    = $clog2(NrExits);
    localparam int LogNbPerLane  = $clog2(NbPerLane);
    localparam int SeqIdxBits    = $clog2(NrExits * NbPerLane);
    localparam int InfoPtrBits   = $clog2(InfoDepth);
    localparam int LaneCntBits   = $clog2(LaneDepth + 1);
    localparam int VAddrBankBits = 2;
    localparam int VAddrBits     = SetBits + VAddrBankBits;
    localparam int VdBits        = 6;
    localparam int VstartBits    = 11;
    localparam int CmtCntBits    = 8;

    // vd[msb] selects the accumulator register file region.
    localparam int NrSetPerVreg  = 2;
    localparam int NrSetPerAreg  = 4;
    localparam int AregBaseSet   = 48;

    typedef enum logic [1:0] {
        MODE_UNIT    = 2'd0,
        MODE_STRIDED = 2'd1,
        MODE_CLN2D   = 2'd2,
        MODE_ROW2D   = 2'd3
    } mode_e;

    typedef logic [1:0] sew_t;

    typedef struct packed {
        logic [ReqIdBits-1:0]  req_id;
        mode_e                 mode;
        sew_t                  sew;
        logic [VdBits-1:0]     vd;
        logic [VstartBits-1:0] vstart;
        logic                  vm;
        logic [CmtCntBits-1:0] cmt_cnt;
    } meta_glb_t;

    typedef struct packed {
        logic [ReqIdBits-1:0]     req_id;
        mode_e                    mode;
        sew_t                     sew;
        logic                     vm;
        logic [CmtCntBits-1:0]    cmt_cnt;
        logic [SetBits-1:0]       vaddr_set;
        logic [VAddrBankBits-1:0] vaddr_bank;
    } shf_info_t;

    typedef struct packed {
        logic [DLEN-1:0]          data;
        logic [NbPerLane-1:0]     nbe;
        logic [ReqIdBits-1:0]     req_id;
        logic [SetBits-1:0]       vaddr_set;
        logic [VAddrBankBits-1:0] vaddr_bank;
    } tx_lane_t;

    // Circular queue pointer: the wrap flag tells full from empty.
    typedef struct packed {
        logic                   flag;
        logic [InfoPtrBits-1:0] value;
    } info_ptr_t;

    function automatic info_ptr_t ptr_inc(input info_ptr_t p);
        logic [InfoPtrBits:0] raw;
        raw = p;
        return info_ptr_t'(raw + 1'b1);
    endfunction

    function automatic logic is_cln2d(input mode_e m);
        return m == MODE_CLN2D;
    endfunction

    // Lane-order nibble shf -> sequential nibble; element e lives in lane e % nr_exits.
    function automatic logic [SeqIdxBits-1:0] query_seq_idx(input int nr_exits,
                                                            input logic [SeqIdxBits-1:0] shf,
                                                            input sew_t sew);
        int lane, off, k, n, nb_log;
        nb_log = int'(sew) + 1;
        lane   = int'(shf) >> LogNbPerLane;
        off    = int'(shf) & (NbPerLane - 1);
        k      = off >> nb_log;
        n      = off & ((1 << nb_log) - 1);
        return SeqIdxBits'(((k * nr_exits + lane) << nb_log) | n);
    endfunction

    // Column loads skew the source lane by the lane-local element index.
    function automatic logic [SeqIdxBits-1:0] query_seq_idx_2d_cln(input int nr_exits,
                                                                   input logic [SeqIdxBits-1:0] shf,
                                                                   input sew_t sew);
        int lane, off, k, n, nb_log, src;
        nb_log = int'(sew) + 1;
        lane   = int'(shf) >> LogNbPerLane;
        off    = int'(shf) & (NbPerLane - 1);
        k      = off >> nb_log;
        n      = off & ((1 << nb_log) - 1);
        src    = (lane + k) & (nr_exits - 1);
        return SeqIdxBits'(((k * nr_exits + src) << nb_log) | n);
    endfunction

    function automatic logic [SetBits-1:0] vd_base_set(input logic [VdBits-1:0] vd);
        if (vd[VdBits-1]) begin
            return SetBits'(AregBaseSet + int'(vd[VdBits-2:0]) * NrSetPerAreg);
        end
        return SetBits'(int'(vd[VdBits-2:0]) * NrSetPerVreg);
    endfunction

    // The base set occupies the high field; the per-lane word offset adds below it.
    function automatic logic [VAddrBits-1:0] calc_vaddr(input meta_glb_t m);
        logic [VstartBits-1:0] per_lane;
        logic [VstartBits-1:0] word;
        per_lane = m.vstart >> LogNrExits;
        word     = per_lane >> (2'd3 - m.sew);
        return {vd_base_set(m.vd), {VAddrBankBits{1'b0}}} + VAddrBits'(word);
    endfunction

endpackage

// File: rtl/shf_lane_fifo.sv
// Per-lane output FIFO with occupancy count and synchronous flush.
module shf_lane_fifo #(
    parameter int  Depth = 2,
    parameter type T     = logic,
    localparam int CntBits = $clog2(Depth + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               push_i,
    input  T                   data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output T                   data_o,
    output logic               full_o,
    output logic [CntBits-1:0] cnt_o
);

    localparam int PtrBits = (Depth > 1) ? $clog2(Depth) : 1;

    T                   mem_q [Depth];
    logic [PtrBits-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntBits-1:0] cnt_q;
    logic               pop;

    function automatic logic [PtrBits-1:0] next_ptr(input logic [PtrBits-1:0] p);
        return (p == PtrBits'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid_o = cnt_q != '0;
    assign pop     = valid_o && ready_i;
    assign full_o  = cnt_q == CntBits'(Depth);
    assign cnt_o   = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)    rd_ptr_q <= next_ptr(rd_ptr_q);
            if (push_i && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (!push_i && pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) push_i |-> !full_o);

endmodule

// File: rtl/shuffle_unit_mq.sv
// Load shuffle stage: scatters sequential nibble beats into per-lane order and
// buffers them in independent lane FIFOs, driven by a queue of instruction info.
module shuffle_unit_mq
    import vlsu_shuffle_pkg::*;
(
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   flush_i,
    input  logic                                   meta_valid_i,
    output logic                                   meta_ready_o,
    input  meta_glb_t                              meta_i,
    input  logic                                   seq_valid_i,
    output logic                                   seq_ready_o,
    input  logic [NrExits*DLEN-1:0]                seq_nb_i,
    input  logic [NrExits*NbPerLane-1:0]           seq_en_i,
    input  logic [NrExits-1:0]                     mask_valid_i,
    input  logic [NrExits-1:0][NbPerLane-1:0]      mask_bits_i,
    output logic                                   mask_ready_o,
    output logic [NrExits-1:0]                     txs_valid_o,
    input  logic [NrExits-1:0]                     txs_ready_i,
    output tx_lane_t [NrExits-1:0]                 txs_o,
    output logic [NrExits-1:0][LaneCntBits-1:0]    lane_cnt_o,
    output logic [NrReqIds-1:0]                    vinsn_done_o
);

    // Handshakes: a transfer happens in a cycle where valid and ready are both
    // high; valid never waits on ready, and ready never looks at txs_ready_i.
    shf_info_t              info_q [InfoDepth];
    info_ptr_t              enq_ptr_q, deq_ptr_q;
    shf_info_t              head, new_info;
    logic [VAddrBits-1:0]   new_vaddr;
    logic                   info_empty, info_full, meta_fire, commit, head_done;
    logic [NrExits-1:0]     lane_full;
    tx_lane_t [NrExits-1:0] lane_tx;
    logic [NrExits-1:0][DLEN-1:0]                      lane_data;
    logic [NrExits-1:0][NbPerLane-1:0]                 lane_nbe;
    logic [NrExits-1:0][NbPerLane-1:0][SeqIdxBits-1:0] seq_idx;

    assign info_empty   = enq_ptr_q == deq_ptr_q;
    assign info_full    = (enq_ptr_q.value == deq_ptr_q.value) && (enq_ptr_q.flag != deq_ptr_q.flag);
    assign head         = info_q[deq_ptr_q.value];
    assign meta_ready_o = !info_full;
    assign meta_fire    = meta_valid_i && !info_full && !flush_i;
    assign seq_ready_o  = !info_empty && !(|lane_full) && (head.vm || &mask_valid_i) && !flush_i;
    assign commit       = seq_valid_i && seq_ready_o;
    assign head_done    = commit && (head.cmt_cnt == '0);
    assign mask_ready_o = commit && !head.vm;

    always_comb begin
        vinsn_done_o = '0;
        if (head_done) vinsn_done_o[head.req_id] = 1'b1;
    end

    assign new_vaddr = calc_vaddr(meta_i);
    assign new_info  = '{req_id:     meta_i.req_id,
                         mode:       meta_i.mode,
                         sew:        meta_i.sew,
                         vm:         meta_i.vm,
                         cmt_cnt:    meta_i.cmt_cnt,
                         vaddr_set:  new_vaddr[VAddrBits-1 -: SetBits],
                         vaddr_bank: new_vaddr[VAddrBankBits-1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enq_ptr_q <= '0;
            deq_ptr_q <= '0;
        end else if (flush_i) begin
            enq_ptr_q <= '0;
            deq_ptr_q <= '0;
        end else begin
            if (meta_fire) enq_ptr_q <= ptr_inc(enq_ptr_q);
            if (head_done) deq_ptr_q <= ptr_inc(deq_ptr_q);
        end
    end

    // Enqueue and head update never hit the same slot: full blocks enqueue, empty blocks commit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < InfoDepth; i++) info_q[i] <= '0;
        end else begin
            if (meta_fire) info_q[enq_ptr_q.value] <= new_info;
            if (commit && !head_done) begin
                info_q[deq_ptr_q.value].vaddr_set <= head.vaddr_set + 1'b1;
                info_q[deq_ptr_q.value].cmt_cnt   <= head.cmt_cnt - 1'b1;
            end
        end
    end

    for (genvar l = 0; l < NrExits; l++) begin : g_lane
        for (genvar o = 0; o < NbPerLane; o++) begin : g_nb
            localparam logic [SeqIdxBits-1:0] Shf = SeqIdxBits'(l * NbPerLane + o);
            assign seq_idx[l][o] = is_cln2d(head.mode)
                                 ? query_seq_idx_2d_cln(NrExits, Shf, head.sew)
                                 : query_seq_idx(NrExits, Shf, head.sew);
            assign lane_data[l][o*4 +: 4] = seq_nb_i[{seq_idx[l][o], 2'b00} +: 4];
            assign lane_nbe[l][o] = seq_en_i[seq_idx[l][o]] && (head.vm || mask_bits_i[l][o]);
        end

        assign lane_tx[l] = '{data:       lane_data[l],
                              nbe:        lane_nbe[l],
                              req_id:     head.req_id,
                              vaddr_set:  head.vaddr_set,
                              vaddr_bank: head.vaddr_bank};

        shf_lane_fifo #(
            .Depth (LaneDepth),
            .T     (tx_lane_t)
        ) u_lane_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (commit),
            .data_i  (lane_tx[l]),
            .valid_o (txs_valid_o[l]),
            .ready_i (txs_ready_i[l]),
            .data_o  (txs_o[l]),
            .full_o  (lane_full[l]),
            .cnt_o   (lane_cnt_o[l])
        );
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) seq_valid_i |-> !info_empty);
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     txs_valid_o[0] |-> (int'(txs_o[0].vaddr_set) < NrVRFSets));

endmodule

// File: tb/tb_shuffle_unit_mq.sv
// Directed bench for shuffle_unit_mq with hand-computed expected values.
module tb_shuffle_unit_mq;
    import vlsu_shuffle_pkg::*;

    logic                                clk_i = 1'b0;
    logic                                rst_ni;
    logic                                flush_i;
    logic                                meta_valid_i;
    logic                                meta_ready_o;
    meta_glb_t                           meta_i;
    logic                                seq_valid_i;
    logic                                seq_ready_o;
    logic [NrExits*DLEN-1:0]             seq_nb_i;
    logic [NrExits*NbPerLane-1:0]        seq_en_i;
    logic [NrExits-1:0]                  mask_valid_i;
    logic [NrExits-1:0][NbPerLane-1:0]   mask_bits_i;
    logic                                mask_ready_o;
    logic [NrExits-1:0]                  txs_valid_o;
    logic [NrExits-1:0]                  txs_ready_i;
    tx_lane_t [NrExits-1:0]              txs_o;
    logic [NrExits-1:0][LaneCntBits-1:0] lane_cnt_o;
    logic [NrReqIds-1:0]                 vinsn_done_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_unit [NrExits];
    logic [63:0] exp_cln  [NrExits];

    shuffle_unit_mq dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .meta_valid_i (meta_valid_i),
        .meta_ready_o (meta_ready_o),
        .meta_i       (meta_i),
        .seq_valid_i  (seq_valid_i),
        .seq_ready_o  (seq_ready_o),
        .seq_nb_i     (seq_nb_i),
        .seq_en_i     (seq_en_i),
        .mask_valid_i (mask_valid_i),
        .mask_bits_i  (mask_bits_i),
        .mask_ready_o (mask_ready_o),
        .txs_valid_o  (txs_valid_o),
        .txs_ready_i  (txs_ready_i),
        .txs_o        (txs_o),
        .lane_cnt_o   (lane_cnt_o),
        .vinsn_done_o (vinsn_done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic meta_glb_t mk_meta(input logic [ReqIdBits-1:0] req, input mode_e mode,
                                          input sew_t sew, input logic [VdBits-1:0] vd,
                                          input logic [VstartBits-1:0] vstart, input logic vm,
                                          input logic [CmtCntBits-1:0] cmt);
        return '{req_id: req, mode: mode, sew: sew, vd: vd, vstart: vstart, vm: vm, cmt_cnt: cmt};
    endfunction

    task automatic send_meta(input meta_glb_t m);
        meta_valid_i = 1'b1;
        meta_i       = m;
        tick();
        meta_valid_i = 1'b0;
    endtask

    initial begin
        // Byte j of the beat holds value j.
        exp_unit[0] = 64'h1c1814100c080400;
        exp_unit[1] = 64'h1d1915110d090501;
        exp_unit[2] = 64'h1e1a16120e0a0602;
        exp_unit[3] = 64'h1f1b17130f0b0703;
        exp_cln[0]  = 64'h1716151403020100;
        exp_cln[1]  = 64'h1b1a191807060504;
        exp_cln[2]  = 64'h1f1e1d1c0b0a0908;
        exp_cln[3]  = 64'h131211100f0e0d0c;

        rst_ni       = 1'b0;
        flush_i      = 1'b0;
        meta_valid_i = 1'b0;
        meta_i       = '0;
        seq_valid_i  = 1'b0;
        seq_nb_i     = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
        seq_en_i     = '1;
        mask_valid_i = '0;
        mask_bits_i  = '1;
        txs_ready_i  = '1;
        #2;
        chk("rst_meta_ready", 64'(meta_ready_o), 64'd1);
        chk("rst_seq_ready", 64'(seq_ready_o), 64'd0);
        chk("rst_mask_ready", 64'(mask_ready_o), 64'd0);
        chk("rst_txs_valid", 64'(txs_valid_o), 64'd0);
        chk("rst_lane_cnt", 64'(lane_cnt_o), 64'd0);
        chk("rst_vinsn_done", 64'(vinsn_done_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        tick();

        // Back-to-back unit-stride beats, sew=8, vd=2.
        send_meta(mk_meta(3'd1, MODE_UNIT, 2'd0, 6'd2, 11'd0, 1'b1, 8'd3));
        seq_valid_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            #1;
            chk("b2b_seq_ready", 64'(seq_ready_o), 64'd1);
            chk("b2b_vinsn_done", 64'(vinsn_done_o), (b == 3) ? 64'h02 : 64'h00);
            tick();
            chk("b2b_txs_valid", 64'(txs_valid_o), 64'hf);
            chk("b2b_vaddr_set", 64'(txs_o[0].vaddr_set), 64'(4 + b));
            chk("b2b_lane1_cnt", 64'(lane_cnt_o[1]), 64'd1);
            if (b == 0) begin
                for (int l = 0; l < NrExits; l++) chk("b2b_lane_data", txs_o[l].data, exp_unit[l]);
                chk("b2b_lane0_nbe", 64'(txs_o[0].nbe), 64'hffff);
            end
        end
        seq_valid_i = 1'b0;
        #1;
        chk("b2b_idle_seq_ready", 64'(seq_ready_o), 64'd0);
        tick();
        chk("b2b_drained", 64'(txs_valid_o), 64'd0);

        // Lane 1 backpressure with LaneDepth=2.
        txs_ready_i = 4'b1101;
        send_meta(mk_meta(3'd2, MODE_UNIT, 2'd3, 6'd0, 11'd0, 1'b1, 8'd2));
        seq_valid_i = 1'b1;
        #1;
        chk("bp_ready0", 64'(seq_ready_o), 64'd1);
        tick();
        chk("bp_cnt1_a", 64'(lane_cnt_o[1]), 64'd1);
        chk("bp_ready1", 64'(seq_ready_o), 64'd1);
        tick();
        chk("bp_cnt1_full", 64'(lane_cnt_o[1]), 64'd2);
        chk("bp_cnt0", 64'(lane_cnt_o[0]), 64'd1);
        chk("bp_stalled", 64'(seq_ready_o), 64'd0);
        tick();
        chk("bp_cnt1_hold", 64'(lane_cnt_o[1]), 64'd2);
        chk("bp_cnt0_drain", 64'(lane_cnt_o[0]), 64'd0);
        txs_ready_i = 4'b1111;
        #1;
        chk("bp_no_bypass", 64'(seq_ready_o), 64'd0);
        tick();
        chk("bp_cnt1_freed", 64'(lane_cnt_o[1]), 64'd1);
        chk("bp_ready_again", 64'(seq_ready_o), 64'd1);
        chk("bp_vinsn_done", 64'(vinsn_done_o), 64'h04);
        tick();
        seq_valid_i = 1'b0;
        chk("bp_cnt1_pushpop", 64'(lane_cnt_o[1]), 64'd1);
        repeat (2) tick();

        // Masked beat: commit waits for every lane's mask.
        send_meta(mk_meta(3'd3, MODE_UNIT, 2'd3, 6'd1, 11'd20, 1'b0, 8'd0));
        seq_en_i        = 64'hffff_ffff_ffff_0f0f;
        mask_bits_i[0]  = 16'h00ff;
        mask_valid_i    = 4'b0111;
        seq_valid_i     = 1'b1;
        #1;
        chk("mask_partial_ready", 64'(seq_ready_o), 64'd0);
        chk("mask_partial_mready", 64'(mask_ready_o), 64'd0);
        tick();
        chk("mask_no_commit", 64'(txs_valid_o), 64'd0);
        mask_valid_i = 4'b1111;
        #1;
        chk("mask_ready", 64'(seq_ready_o), 64'd1);
        chk("mask_mready", 64'(mask_ready_o), 64'd1);
        chk("mask_vinsn_done", 64'(vinsn_done_o), 64'h08);
        tick();
        seq_valid_i  = 1'b0;
        mask_valid_i = 4'b0000;
        #1;
        chk("mask_mready_once", 64'(mask_ready_o), 64'd0);
        chk("mask_lane0_nbe", 64'(txs_o[0].nbe), 64'h000f);
        chk("mask_lane1_nbe", 64'(txs_o[1].nbe), 64'hffff);
        chk("mask_vaddr_set", 64'(txs_o[0].vaddr_set), 64'd3);
        chk("mask_vaddr_bank", 64'(txs_o[0].vaddr_bank), 64'd1);
        chk("mask_req_id", 64'(txs_o[0].req_id), 64'd3);
        seq_en_i    = '1;
        mask_bits_i = '1;
        tick();

        // Fill the info queue, then hold a fifth meta until a slot frees.
        meta_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            meta_i = mk_meta(3'(4 + i), MODE_UNIT, 2'd3, 6'd0, 11'd0, 1'b1, 8'd0);
            tick();
        end
        meta_i = mk_meta(3'd0, MODE_CLN2D, 2'd2, 6'd3, 11'd40, 1'b1, 8'd0);
        #1;
        chk("full_meta_ready", 64'(meta_ready_o), 64'd0);
        tick();
        chk("full_meta_held", 64'(meta_ready_o), 64'd0);
        seq_valid_i = 1'b1;
        #1;
        chk("full_seq_ready", 64'(seq_ready_o), 64'd1);
        chk("full_vinsn_req4", 64'(vinsn_done_o), 64'h10);
        chk("full_no_bypass", 64'(meta_ready_o), 64'd0);
        tick();
        chk("full_slot_freed", 64'(meta_ready_o), 64'd1);
        chk("full_vinsn_req5", 64'(vinsn_done_o), 64'h20);
        tick();
        meta_valid_i = 1'b0;
        chk("full_vinsn_req6", 64'(vinsn_done_o), 64'h40);
        tick();
        chk("full_vinsn_req7", 64'(vinsn_done_o), 64'h80);
        tick();
        chk("cln_vinsn_req0", 64'(vinsn_done_o), 64'h01);
        tick();
        seq_valid_i = 1'b0;
        for (int l = 0; l < NrExits; l++) chk("cln_lane_data", txs_o[l].data, exp_cln[l]);
        chk("cln_vaddr_set", 64'(txs_o[2].vaddr_set), 64'd7);
        chk("cln_vaddr_bank", 64'(txs_o[2].vaddr_bank), 64'd1);
        chk("cln_req_id", 64'(txs_o[3].req_id), 64'd0);
        tick();

        // Flush with two queued metas and full lane FIFOs.
        send_meta(mk_meta(3'd1, MODE_UNIT, 2'd3, 6'd0, 11'd0, 1'b1, 8'd5));
        send_meta(mk_meta(3'd2, MODE_UNIT, 2'd3, 6'd0, 11'd0, 1'b1, 8'd5));
        txs_ready_i = 4'b0000;
        seq_valid_i = 1'b1;
        repeat (2) tick();
        chk("flush_lanes_full", 64'(lane_cnt_o), 64'haa);
        chk("flush_pre_ready", 64'(seq_ready_o), 64'd0);
        flush_i      = 1'b1;
        meta_valid_i = 1'b1;
        meta_i       = mk_meta(3'd3, MODE_UNIT, 2'd3, 6'd0, 11'd0, 1'b1, 8'd0);
        #1;
        chk("flush_blocks", 64'(seq_ready_o), 64'd0);
        chk("flush_no_done", 64'(vinsn_done_o), 64'd0);
        tick();
        flush_i      = 1'b0;
        meta_valid_i = 1'b0;
        seq_valid_i  = 1'b0;
        txs_ready_i  = 4'b1111;
        #1;
        chk("flush_txs_valid", 64'(txs_valid_o), 64'd0);
        chk("flush_lane_cnt", 64'(lane_cnt_o), 64'd0);
        chk("flush_meta_ready", 64'(meta_ready_o), 64'd1);
        chk("flush_info_empty", 64'(seq_ready_o), 64'd0);
        chk("flush_done_quiet", 64'(vinsn_done_o), 64'd0);
        tick();

        // Asynchronous reset mid-burst.
        send_meta(mk_meta(3'd1, MODE_UNIT, 2'd3, 6'd0, 11'd0, 1'b1, 8'd5));
        txs_ready_i = 4'b0000;
        seq_valid_i = 1'b1;
        tick();
        chk("arst_pre_valid", 64'(txs_valid_o), 64'hf);
        #2;
        rst_ni      = 1'b0;
        seq_valid_i = 1'b0;
        #1;
        chk("arst_txs_valid", 64'(txs_valid_o), 64'd0);
        chk("arst_lane_cnt", 64'(lane_cnt_o), 64'd0);
        chk("arst_meta_ready", 64'(meta_ready_o), 64'd1);
        chk("arst_seq_ready", 64'(seq_ready_o), 64'd0);
        chk("arst_vinsn_done", 64'(vinsn_done_o), 64'd0);
        tick();
        rst_ni      = 1'b1;
        txs_ready_i = 4'b1111;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shuffle_unit_mq.md
Name: shuffle_unit_mq

Overview:
- Multi-queue successor to the VLSU load shuffle stage. Takes sequential load beats (nibble data plus nibble enables) and scatters them into NrExits lane-local nibble order, using the shared query_seq_idx / query_seq_idx_2d_cln functions.
- Each lane has its own LaneDepth-entry output FIFO. A new beat commits when every lane has space, not only when every lane is empty, so lanes drain independently and back-to-back beats sustain 1 beat/cycle.
- Adds a synchronous flush and per-lane occupancy reporting.
- Sits between SequentialLoad and the lane VRF write ports; sends vinsn_done to the PE response path.

Parameters:
- NrExits, 4, number of lanes; power of two, ≥2.
- DLEN, 64, per-lane datapath bits; nibbles per lane NbPerLane = DLEN/4.
- InfoDepth, 4, shuffle-info queue entries; power of two.
- LaneDepth, 2, per-lane output FIFO entries; ≥1.
- NrReqIds, 8, reqId space; width of the vinsn_done vector.
- NrVRFSets, 64, VRF sets; vaddr_set width SetBits = clog2(NrVRFSets).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous flush of all queues.
- meta_valid_i  in  1  meta info valid.
- meta_ready_o  out  1  meta info accepted.
- meta_i  in  meta_glb_t  reqId, mode, sew, vd, vstart, vm, cmtCnt.
- seq_valid_i  in  1  sequential beat valid.
- seq_ready_o  out  1  sequential beat accepted.
- seq_nb_i  in  NrExits*DLEN  nibble data.
- seq_en_i  in  NrExits*DLEN/4  nibble enables.
- mask_valid_i  in  NrExits  per-lane mask valid.
- mask_bits_i  in  NrExits*NbPerLane  per-lane nibble mask.
- mask_ready_o  out  1  mask consumed.
- txs_valid_o  out  NrExits  lane output valid.
- txs_ready_i  in  NrExits  lane output ready.
- txs_o  out  NrExits*tx_lane_t  data, nbe, reqId, vaddr_set, vaddr_bank.
- lane_cnt_o  out  NrExits*clog2(LaneDepth+1)  FIFO occupancy per lane.
- vinsn_done_o  out  NrReqIds  one-cycle done pulse.

Behaviour:
- Reset values:
  - meta_ready_o=1; seq_ready_o=0; mask_ready_o=0.
  - txs_valid_o=0; lane_cnt_o=0; vinsn_done_o=0.
  - Info and lane pointers/flags = 0.
- Info queue:
  - Circular queue with wrap flag. meta_ready_o = !full; no same-cycle bypass when full.
  - On enqueue, store vaddr = vd_base_set + ((vstart>>log2 NrExits) >> (3-sew)).
  - vd_base_set = vd[msb] ? AregBaseSet + vd[msb-1:0]*NrSetPerAreg : vd[msb-1:0]*NrSetPerVreg.
  - Split vaddr into vaddr_set (high bits) and vaddr_bank (low bits).
- Commit condition:
  - seq_ready_o = !info_empty && all lanes (cnt < LaneDepth) && (head.vm || &mask_valid_i) && !flush_i.
  - Lane space counts only current occupancy; no same-cycle pop bypass, so txs_ready_i has no combinational path to seq_ready_o.
  - commit = seq_valid_i && seq_ready_o. mask_ready_o = commit && !head.vm.
- Shuffle on commit, for every lane l and offset o:
  - shf=l*NbPerLane+o.
  - seq = isCln2D(mode) ? query_seq_idx_2d_cln(NrExits, shf, sew) : query_seq_idx(NrExits, shf, sew).
  - data nibble o = nb[seq]; nbe[o] = en[seq] && (vm || mask_bits[l][o]).
  - Push to all NrExits FIFOs in the same cycle with reqId, vaddr_set, vaddr_bank.
- Head update on commit:
  - vaddr_set++, wrapping mod 2^SetBits.
  - If cmtCnt≠0, decrement it.
  - If cmtCnt==0, dequeue the head and pulse vinsn_done_o[reqId] in the commit cycle (combinational).
- Lane FIFOs:
  - txs_valid_o[l] = cnt≠0; pop on valid&&ready.
  - Push and pop in the same cycle keeps the count; push into a full FIFO is impossible by construction.
- Latency: commit to txs_valid_o is 1 cycle.
- Simultaneous events:
  - Meta enqueue and head dequeue in the same cycle are both honoured; the count is unchanged.
  - An enqueue into a queue that was empty is visible as head the next cycle.
- flush_i:
  - Blocks commit in the same cycle.
  - Next cycle: info queue and all lane FIFOs empty; no vinsn_done pulse.
  - A meta enqueue in the same cycle as flush is discarded.
- Reset mid-operation: all state clears immediately; in-flight data is lost.
- Assertions:
  - seq_valid_i implies !info_empty.
  - For txs_valid_o[0], vaddr_set < NrVRFSets.
  - No push into a full lane FIFO.

Decomposition:
- vlsu_shuffle_pkg holds: shf_info_t, tx_lane_t, query functions, vaddr split constants (VAddrBits, VAddrBankBits), AregBaseSet, NrSetPerVreg, NrSetPerAreg.
- The info queue reuses CircularQueuePtrTemplate for its enqueue and dequeue pointers.
- One natural sub-module: shf_lane_fifo (parametrised depth/type, count output, flush), instantiated NrExits times.

Test Plan:
- Meta vd=2, vstart=0, sew=0, cmtCnt=3, vm=1; 4 back-to-back beats with txs_ready_i=all 1 → 4 commits in 4 cycles; vaddr_set 2*NrSetPerVreg..+3; vinsn_done_o[reqId] pulses only on the 4th commit.
- LaneDepth=2; hold txs_ready_i[1]=0 and push 3 beats → lane_cnt_o[1]=2, seq_ready_o=0 after 2 commits. Release ready → 3rd commit one cycle after lane 1's count drops below 2.
- vm=0, mask_valid_i=4'b0111 → no commit. Set it to 4'b1111 with mask_bits lane0=16'h00FF → lane0 nbe=16'h00FF ANDed with en; mask_ready_o pulses once.
- Fill the info queue with 4 metas → meta_ready_o=0. A 5th meta is held until the head dequeues; enqueue is accepted the cycle after the dequeue frees an entry.
- mode=2D column, sew=2 with an incrementing-nibble pattern → every lane nibble equals the query_seq_idx_2d_cln golden model.
- flush_i with 2 queued metas and full lane FIFOs → next cycle txs_valid_o=0, meta_ready_o=1, no vinsn_done; rst_ni low mid-burst → all outputs return to reset values asynchronously.
